neuron_train_sequencer: RTL

Upstream driver for the single-output learning layer. Holds a small sample store of input vectors and targets, and runs training epochs over them: per sample it drives `in`, `expected_out`, `valid` and `learn`, waits a fixed settle time, captures the layer's `out`, and accumulates absolute error. After each epoch it reports the summed error and stops after `EPOCHS` epochs or when an epoch error is at or below a threshold.

---
 rtl/neuron_train_sequencer_pkg.sv | 22 ++
 rtl/neuron_train_sequencer_sample_store.sv | 30 +++
 rtl/neuron_train_sequencer.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/neuron_train_sequencer_pkg.sv
// Shared types for the training sequencer: fixed-point sample types, FSM states
// and the error-accumulator width helper.
package neuron_train_sequencer_pkg;
  localparam int ZW = 8;

  typedef logic        [ZW-1:0] zero2one_t;
  typedef logic signed [ZW-1:0] frac_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CAPTURE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  // DEPTH samples of at most 2**ZW-1 error each fit without overflow
  function automatic int errw(input int depth);
    return ZW + $clog2(depth);
  endfunction
endpackage

// File: rtl/neuron_train_sequencer_sample_store.sv
// DEPTH-entry store of {input vector, target}; one write port, one async read port.
module sample_store
  import neuron_train_sequencer_pkg::*;
#(
  parameter  int N     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  zero2one_t [N-1:0]   wvec,
  input  zero2one_t           wtgt,
  input  logic [AW-1:0]       raddr,
  output zero2one_t [N-1:0]   rvec,
  output zero2one_t           rtgt
);
  zero2one_t [N-1:0] vec_mem [DEPTH];
  zero2one_t         tgt_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      vec_mem[waddr] <= wvec;
      tgt_mem[waddr] <= wtgt;
    end
  end

  assign rvec = vec_mem[raddr];
  assign rtgt = tgt_mem[raddr];
endmodule

// File: rtl/neuron_train_sequencer.sv
// Drives training epochs over the sample store into a single-output layer and
// reports the summed absolute error per epoch, with early stop on a threshold.
module neuron_train_sequencer
  import neuron_train_sequencer_pkg::*;
#(
  parameter  int N      = 16,
  parameter  int DEPTH  = 8,
  parameter  int EPOCHS = 4,
  parameter  int SETTLE = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int ERRW   = errw(DEPTH),
  localparam int ECW    = $clog2(EPOCHS+1),
  localparam int SW     = $clog2(SETTLE+1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  zero2one_t [N-1:0] load_in,
  input  zero2one_t         load_target,
  input  logic              start,
  input  logic [ERRW-1:0]   threshold,
  output zero2one_t [N-1:0] in,
  output zero2one_t [0:0]   expected_out,
  output logic              valid,
  output logic              learn,
  input  zero2one_t [0:0]   out,
  output logic              busy,
  output logic              epoch_done,
  output logic [ERRW-1:0]   epoch_error,
  output logic [ECW-1:0]    epoch_count,
  output logic              done
);
  state_t            state;
  logic [AW-1:0]     idx;
  logic [SW-1:0]     settle_cnt;
  logic [ERRW-1:0]   acc, thr, sum;
  logic              stop;
  logic              store_we;
  logic [AW-1:0]     rd_addr;
  zero2one_t [N-1:0] rd_vec, nxt_vec;
  zero2one_t         rd_tgt, nxt_tgt;
  zero2one_t         err;

  assign store_we = load_en && (state == S_IDLE);

  // Every entry into DRIVE comes from IDLE/EPOCH_END (index 0) or CAPTURE (index+1)
  assign rd_addr = (state == S_CAPTURE) ? idx + 1'b1 : '0;

  sample_store #(.N(N), .DEPTH(DEPTH)) u_store (
    .clock (clock),
    .we    (store_we),
    .waddr (load_addr),
    .wvec  (load_in),
    .wtgt  (load_target),
    .raddr (rd_addr),
    .rvec  (rd_vec),
    .rtgt  (rd_tgt)
  );

  // A write in the start cycle must be visible to the first driven sample
  assign nxt_vec = (store_we && load_addr == rd_addr) ? load_in     : rd_vec;
  assign nxt_tgt = (store_we && load_addr == rd_addr) ? load_target : rd_tgt;

  assign err = (out[0] >= expected_out[0]) ? out[0] - expected_out[0]
                                           : expected_out[0] - out[0];
  assign sum = acc + ERRW'(err);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      acc          <= '0;
      thr          <= '0;
      stop         <= 1'b0;
      in           <= '0;
      expected_out <= '0;
      valid        <= 1'b0;
      learn        <= 1'b0;
      busy         <= 1'b0;
      epoch_done   <= 1'b0;
      epoch_error  <= '0;
      epoch_count  <= '0;
      done         <= 1'b0;
    end else begin
      valid      <= 1'b0;
      learn      <= 1'b0;
      epoch_done <= 1'b0;
      done       <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          thr             <= threshold;
          epoch_count     <= '0;
          idx             <= '0;
          acc             <= '0;
          busy            <= 1'b1;
          valid           <= 1'b1;
          learn           <= 1'b1;
          in              <= nxt_vec;
          expected_out[0] <= nxt_tgt;
          state           <= S_DRIVE;
        end
        S_DRIVE: begin
          settle_cnt <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (settle_cnt == SW'(SETTLE-1)) state <= S_CAPTURE;
          else                             settle_cnt <= settle_cnt + 1'b1;
        end
        S_CAPTURE: begin
          acc <= sum;
          if (idx == AW'(DEPTH-1)) begin
            idx         <= '0;
            epoch_error <= sum;
            epoch_done  <= 1'b1;
            epoch_count <= epoch_count + 1'b1;
            stop        <= (int'(epoch_count) + 1 == EPOCHS) || (sum <= thr);
            state       <= S_EPOCH_END;
          end else begin
            idx             <= idx + 1'b1;
            valid           <= 1'b1;
            learn           <= 1'b1;
            in              <= nxt_vec;
            expected_out[0] <= nxt_tgt;
            state           <= S_DRIVE;
          end
        end
        S_EPOCH_END: begin
          if (stop) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            acc             <= '0;
            valid           <= 1'b1;
            learn           <= 1'b1;
            in              <= nxt_vec;
            expected_out[0] <= nxt_tgt;
            state           <= S_DRIVE;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
